uart_frame_rx: RTL and testbench
================================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, the bit period in clocks, matching the upstream receiver.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, the maximum payload bytes per frame (range 1..255).
REQ-003 The block SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-004 The block SHALL have parameter TIMEOUT_CLKS, default 10*CLKS_PER_BIT*10, the inter-byte timeout in clocks.
REQ-005 The block SHALL have port clock, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port i_reset_n, input, 1 bit, reset; asynchronous assert, active-low.
REQ-007 The block SHALL have port i_data_avail, input, 1 bit, byte strobe from the UART receiver; one byte per high cycle.
REQ-008 The block SHALL have port i_data_byte, input, 8 bits, received byte; valid when i_data_avail=1.
REQ-009 The block SHALL have port o_data_valid, output, 1 bit, payload byte available.
REQ-010 The block SHALL have port o_data_byte, output, 8 bits, payload byte.
REQ-011 The block SHALL have port o_data_last, output, 1 bit, marks the final payload byte of the frame.
REQ-012 The block SHALL have port i_data_ready, input, 1 bit, consumer ready.
REQ-013 The block SHALL have port o_frame_err, output, 1 bit, one-cycle error pulse.
REQ-014 The block SHALL have port o_err_code, output, 2 bits: 01 bad length, 10 bad checksum, 11 timeout; held until the next error.
REQ-015 The block SHALL have port o_overrun, output, 1 bit, one-cycle pulse when a byte is dropped during DRAIN.

Function
REQ-016 The frame format SHALL be SYNC, LEN, LEN payload bytes, CSUM, where (LEN + sum(payload) + CSUM) mod 256 == 0.
REQ-017 The FSM states SHALL be IDLE, LEN, PAYLOAD, CSUM and DRAIN.
REQ-018 IDLE: a strobe with byte==SYNC_BYTE SHALL go to LEN; any other byte SHALL be discarded silently with no error.
REQ-019 LEN: LEN==0 or LEN>MAX_LEN SHALL pulse o_frame_err with code 01 and go to IDLE; otherwise the block SHALL store LEN, seed the 8-bit running sum with LEN, and go to PAYLOAD.
REQ-020 PAYLOAD: each strobe SHALL write the byte into buffer[index], add it to the sum mod 256, and increment index; after the LEN-th byte the block SHALL go to CSUM.
REQ-021 CSUM: if (sum + byte) mod 256 == 0 the block SHALL go to DRAIN; otherwise it SHALL pulse o_frame_err with code 10 and go to IDLE, discarding the buffer.
REQ-022 o_data_valid SHALL rise on the cycle after the CSUM strobe (1-cycle latency).
REQ-023 DRAIN: the block SHALL present buffer[0..LEN-1] in order; the byte SHALL advance only on o_data_valid & i_data_ready; data SHALL be held stable while valid=1 and ready=0.
REQ-024 o_data_last SHALL be 1 with the byte at index LEN-1; the handshake on that byte SHALL return the block to IDLE with valid=0 on the next cycle.
REQ-025 Any i_data_avail during DRAIN SHALL drop the byte and pulse o_overrun on the following cycle; the state SHALL be unaffected.
REQ-026 A timeout counter SHALL clear on every strobe and in IDLE/DRAIN; in LEN/PAYLOAD/CSUM, reaching TIMEOUT_CLKS-1 SHALL pulse o_frame_err with code 11 and go to IDLE.
REQ-027 When a strobe and timeout coincide, the strobe SHALL win and the counter SHALL clear.
REQ-028 A SYNC_BYTE value appearing mid-frame SHALL be treated as data, with no resynchronisation.

Reset
REQ-029 Reset assertion SHALL immediately force: state=IDLE, index=0, sum=0, counter=0, o_data_valid=0, o_data_last=0, o_frame_err=0, o_overrun=0, o_err_code=00, o_data_byte=00.
REQ-030 Reset mid-frame or mid-DRAIN SHALL abandon the frame with no error pulse; buffer contents need no reset.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state encoding, the error-code constants, and the SYNC_BYTE default.
REQ-032 The payload store SHALL be sub-module uart_frame_buf: MAX_LEN x 8 registers, 1 write port, 1 read port addressed by the drain index.

Verification
REQ-033 Bytes A5 03 11 22 33 97 with ready=1 SHALL produce 11, 22, 33 on consecutive cycles, last=1 on 33, and no error.
REQ-034 Bytes A5 02 10 20 00 SHALL give o_frame_err pulse, code 10, no valid, and the state SHALL be IDLE.
REQ-035 Bytes A5 00, then separately A5 11 (MAX_LEN=16), SHALL each give an error pulse with code 01.
REQ-036 Bytes A5 02 10 followed by TIMEOUT_CLKS idle cycles SHALL give a pulse with code 11; a following good frame SHALL be accepted.
REQ-037 The REQ-033 frame with ready held 0 for 50 cycles, plus a byte 55 strobed meanwhile, SHALL hold 11 stable, pulse o_overrun once, and then drain all 3 bytes intact.
REQ-038 i_reset_n low for 1 cycle after A5 03 11 SHALL be followed by A5 01 FF 00 producing the single byte FF with last=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame receiver: FSM encoding, error codes
// and the default start-of-frame marker.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // A frame is good when the running sum plus the checksum byte wraps to zero.
    function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
        return (sum + csum) == 8'h00;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x 8 register array, one write port, one
// asynchronous read port addressed by the drain index.
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser behind a byte UART receiver: SYNC, LEN, payload, CSUM.
// Checked payload is buffered and then drained over a valid/ready handshake.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | hunting for SYNC_BYTE, other bytes dropped silently
// ST_LEN     | waiting for the length byte
// ST_PAYLOAD | storing LEN payload bytes and accumulating the sum
// ST_CSUM    | waiting for the checksum byte
// ST_DRAIN   | presenting buffered bytes to the consumer, new bytes overrun
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CLKS = 10 * CLKS_PER_BIT * 10
) (
    input  logic       clock,
    input  logic       i_reset_n,
    input  logic       i_data_avail,
    input  logic [7:0] i_data_byte,
    output logic       o_data_valid,
    output logic [7:0] o_data_byte,
    output logic       o_data_last,
    input  logic       i_data_ready,
    output logic       o_frame_err,
    output logic [1:0] o_err_code,
    output logic       o_overrun
);

    localparam int             AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             CW       = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]     LEN_MAX  = 8'(MAX_LEN);

    state_t        state, state_nxt;
    logic [7:0]    len, len_nxt;
    logic [7:0]    sum, sum_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    err_code_nxt;
    logic          err_set;
    logic          ovr_set;
    logic          buf_we;
    logic [7:0]    buf_rd;

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clock   (clock),
        .wr_en   (buf_we),
        .wr_addr (idx[AW-1:0]),
        .wr_data (i_data_byte),
        .rd_addr (idx[AW-1:0]),
        .rd_data (buf_rd)
    );

    assign o_data_valid = (state == ST_DRAIN);
    assign o_data_last  = o_data_valid && (idx == len - 8'd1);
    assign o_data_byte  = o_data_valid ? buf_rd : 8'h00;

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            len         <= 8'h00;
            sum         <= 8'h00;
            idx         <= 8'h00;
            cnt         <= '0;
            o_frame_err <= 1'b0;
            o_err_code  <= ERR_NONE;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_nxt;
            len         <= len_nxt;
            sum         <= sum_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            o_frame_err <= err_set;
            o_err_code  <= err_code_nxt;
            o_overrun   <= ovr_set;
        end
    end

    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        sum_nxt      = sum;
        idx_nxt      = idx;
        cnt_nxt      = '0;
        err_set      = 1'b0;
        err_code_nxt = o_err_code;
        ovr_set      = 1'b0;
        buf_we       = 1'b0;

        // Inter-byte timeout only runs mid-frame; any strobe takes priority.
        if ((state == ST_LEN || state == ST_PAYLOAD || state == ST_CSUM) && !i_data_avail) begin
            if (cnt == CNT_LAST) begin
                err_set      = 1'b1;
                err_code_nxt = ERR_TIMEOUT;
                state_nxt    = ST_IDLE;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (i_data_avail && i_data_byte == SYNC_BYTE) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (i_data_avail) begin
                    if (i_data_byte == 8'h00 || i_data_byte > LEN_MAX) begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_LEN;
                        state_nxt    = ST_IDLE;
                    end else begin
                        len_nxt   = i_data_byte;
                        sum_nxt   = i_data_byte;
                        idx_nxt   = 8'h00;
                        state_nxt = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_data_avail) begin
                    buf_we  = 1'b1;
                    sum_nxt = sum + i_data_byte;
                    if (idx == len - 8'd1) begin
                        idx_nxt   = 8'h00;
                        state_nxt = ST_CSUM;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            ST_CSUM: begin
                if (i_data_avail) begin
                    if (csum_ok(sum, i_data_byte)) begin
                        idx_nxt   = 8'h00;
                        state_nxt = ST_DRAIN;
                    end else begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_CSUM;
                        state_nxt    = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                ovr_set = i_data_avail;
                if (i_data_ready) begin
                    if (o_data_last) begin
                        idx_nxt   = 8'h00;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: good frames, length/checksum/timeout
// errors, back-pressure with overrun, and reset mid-frame.
module tb_uart_frame_rx;
    import uart_pkg::*;

    localparam int CPB  = 2;
    localparam int MAXL = 16;
    localparam int TO   = 200;

    logic       clock        = 1'b0;
    logic       i_reset_n    = 1'b0;
    logic       i_data_avail = 1'b0;
    logic [7:0] i_data_byte  = 8'h00;
    logic       i_data_ready = 1'b0;
    logic       o_data_valid;
    logic [7:0] o_data_byte;
    logic       o_data_last;
    logic       o_frame_err;
    logic [1:0] o_err_code;
    logic       o_overrun;

    int passed = 0;
    int total  = 0;
    int n_err  = 0;
    int n_ovr  = 0;
    int n_valid = 0;
    int e0, o0, v0;

    always #5 clock = ~clock;

    uart_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .MAX_LEN      (MAXL),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clock        (clock),
        .i_reset_n    (i_reset_n),
        .i_data_avail (i_data_avail),
        .i_data_byte  (i_data_byte),
        .o_data_valid (o_data_valid),
        .o_data_byte  (o_data_byte),
        .o_data_last  (o_data_last),
        .i_data_ready (i_data_ready),
        .o_frame_err  (o_frame_err),
        .o_err_code   (o_err_code),
        .o_overrun    (o_overrun)
    );

    always @(posedge clock) begin
        #2;
        if (o_frame_err)  n_err++;
        if (o_overrun)    n_ovr++;
        if (o_data_valid) n_valid++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] b, input logic last);
        chk({tag, "_valid"}, 32'(o_data_valid), 32'd1);
        chk({tag, "_byte"},  32'(o_data_byte),  32'(b));
        chk({tag, "_last"},  32'(o_data_last),  32'(last));
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        i_data_avail = 1'b1;
        i_data_byte  = b;
        @(negedge clock);
        i_data_avail = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_valid", 32'(o_data_valid), 32'd0);
        chk("rst_last",  32'(o_data_last),  32'd0);
        chk("rst_err",   32'(o_frame_err),  32'd0);
        chk("rst_code",  32'(o_err_code),   32'd0);
        chk("rst_ovr",   32'(o_overrun),    32'd0);
        chk("rst_byte",  32'(o_data_byte),  32'd0);
        chk("rst_state", 32'(dut.state),    32'(ST_IDLE));
        i_reset_n = 1'b1;

        // stray bytes while idle
        e0 = n_err;
        send(8'h33); send(8'h5A);
        chk("idle_discard_err", 32'(n_err - e0), 32'd0);
        chk("idle_discard_state", 32'(dut.state), 32'(ST_IDLE));

        // good 3-byte frame, consumer always ready
        i_data_ready = 1'b1;
        e0 = n_err;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
        chk_out("a0", 8'h11, 1'b0); @(negedge clock);
        chk_out("a1", 8'h22, 1'b0); @(negedge clock);
        chk_out("a2", 8'h33, 1'b1); @(negedge clock);
        chk("a_done_valid", 32'(o_data_valid), 32'd0);
        chk("a_no_err", 32'(n_err - e0), 32'd0);

        // bad checksum
        e0 = n_err; v0 = n_valid;
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        chk("b_pulse", 32'(o_frame_err), 32'd1);
        chk("b_code",  32'(o_err_code),  32'(2'b10));
        @(negedge clock);
        chk("b_pulse_end", 32'(o_frame_err), 32'd0);
        chk("b_one_pulse", 32'(n_err - e0), 32'd1);
        chk("b_no_valid",  32'(n_valid - v0), 32'd0);
        chk("b_state",     32'(dut.state), 32'(ST_IDLE));

        // length zero and length above MAX_LEN
        send(8'hA5); send(8'h00);
        chk("c0_pulse", 32'(o_frame_err), 32'd1);
        chk("c0_code",  32'(o_err_code),  32'(2'b01));
        @(negedge clock);
        chk("c0_code_held", 32'(o_err_code), 32'(2'b01));
        send(8'hA5); send(8'h11);
        chk("c1_pulse", 32'(o_frame_err), 32'd1);
        chk("c1_code",  32'(o_err_code),  32'(2'b01));

        // length exactly MAX_LEN is accepted
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 16; i++) send(8'h01);
        send(8'hE0);
        for (int i = 0; i < 16; i++) begin
            chk("max_byte", 32'(o_data_byte), 32'h01);
            chk("max_last", 32'(o_data_last), 32'(i == 15));
            @(negedge clock);
        end
        chk("max_done_valid", 32'(o_data_valid), 32'd0);

        // sync value inside payload is plain data
        send(8'hA5); send(8'h02); send(8'hA5); send(8'h10); send(8'h49);
        chk_out("s0", 8'hA5, 1'b0); @(negedge clock);
        chk_out("s1", 8'h10, 1'b1); @(negedge clock);

        // inter-byte timeout, then recovery
        send(8'hA5); send(8'h02); send(8'h10);
        repeat (TO - 1) @(negedge clock);
        chk("d_no_early_to", 32'(o_frame_err), 32'd0);
        @(negedge clock);
        chk("d_to_pulse", 32'(o_frame_err), 32'd1);
        chk("d_to_code",  32'(o_err_code),  32'(2'b11));
        chk("d_to_state", 32'(dut.state),   32'(ST_IDLE));
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'hCE);
        chk_out("d0", 8'h10, 1'b0); @(negedge clock);
        chk_out("d1", 8'h20, 1'b1); @(negedge clock);

        // strobe landing on the timeout cycle wins
        e0 = n_err;
        send(8'hA5); send(8'h02);
        repeat (TO - 2) @(negedge clock);
        send(8'h10);
        chk("t_strobe_wins", 32'(o_frame_err), 32'd0);
        send(8'h20); send(8'hCE);
        chk_out("t0", 8'h10, 1'b0); @(negedge clock);
        chk_out("t1", 8'h20, 1'b1); @(negedge clock);
        chk("t_no_err", 32'(n_err - e0), 32'd0);

        // back-pressure with an overrun byte
        i_data_ready = 1'b0;
        o0 = n_ovr;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
        chk_out("e_first", 8'h11, 1'b0);
        send(8'h55);
        chk("e_ovr_pulse", 32'(o_overrun), 32'd1);
        repeat (45) @(negedge clock);
        chk_out("e_hold", 8'h11, 1'b0);
        chk("e_ovr_once", 32'(n_ovr - o0), 32'd1);
        chk("e_state", 32'(dut.state), 32'(ST_DRAIN));
        i_data_ready = 1'b1;
        @(negedge clock);
        chk_out("e1", 8'h22, 1'b0); @(negedge clock);
        chk_out("e2", 8'h33, 1'b1); @(negedge clock);
        chk("e_done_valid", 32'(o_data_valid), 32'd0);

        // reset mid-frame abandons it silently
        e0 = n_err;
        send(8'hA5); send(8'h03); send(8'h11);
        @(negedge clock);
        i_reset_n = 1'b0;
        #1;
        chk("f_async_state", 32'(dut.state), 32'(ST_IDLE));
        @(negedge clock);
        i_reset_n = 1'b1;
        send(8'hA5); send(8'h01); send(8'hFF); send(8'h00);
        chk_out("f0", 8'hFF, 1'b1); @(negedge clock);
        chk("f_done_valid", 32'(o_data_valid), 32'd0);
        chk("f_no_err", 32'(n_err - e0), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
